mype_mac_v2: RTL and testbench

Parametrised multiply-accumulate processing element: a local weight RAM (peram) loaded over a write port, followed by a signed dot product of length `len` between the streamed `ain` operands and the RAM contents. The block is self-sequenced by an internal FSM with a start/busy/dvalid handshake, and the multiply-add is built in RTL rather than from a vendor IP core. It sits in the PE array in the same slot as the earlier 8-bit PE, one instance per column.

---
 rtl/mype_mac_v2.sv | 189 ++++++++++++++++++
 tb/tb_mype_mac_v2.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mype_mac_v2.sv
// mype_mac_v2: weight-RAM multiply-accumulate PE for one array column.
// Ports: aclk; aresetn (sync, active-low); din/addr/we write peram;
//   start/len launch a dot product of len elements; ain/valid/subtract
//   stream the operands; busy/dvalid/dout/ovf report status and result.
// Build option MYPE_SAT_EN: saturating accumulate with sticky ovf;
//   without it the accumulator wraps and ovf is tied low.
module mype_mac_v2 #(
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 24,
    parameter int L_RAM_SIZE = 6
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_W-1:0]     din,
    input  logic [L_RAM_SIZE-1:0] addr,
    input  logic                  we,
    input  logic                  start,
    input  logic [L_RAM_SIZE:0]   len,
    input  logic [DATA_W-1:0]     ain,
    input  logic                  valid,
    input  logic                  subtract,
    output logic                  busy,
    output logic                  dvalid,
    output logic [ACC_W-1:0]      dout,
    output logic                  ovf
);

    localparam int DEPTH = 2 ** L_RAM_SIZE;
    localparam int PW    = 2 * DATA_W;

    localparam logic [L_RAM_SIZE-1:0] IDX_ONE = L_RAM_SIZE'(1);
    localparam logic [L_RAM_SIZE:0]   LEN_ONE = (L_RAM_SIZE + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [DATA_W-1:0]     peram [DEPTH];
    logic [L_RAM_SIZE-1:0] idx;
    logic [L_RAM_SIZE:0]   len_q;
    logic                  drain_cnt;

    logic accept;
    logic launch;
    logic take;
    logic last;

    logic signed [DATA_W-1:0] s0_w;
    logic signed [DATA_W-1:0] s0_a;
    logic                     s0_sub;
    logic                     s0_v;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     s1_p;
    logic                     s1_sub;
    logic                     s1_v;
    logic signed [ACC_W-1:0]  ext;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_nx;

    // busy is still high in the dvalid cycle, which keeps start/we
    // closed until the cycle after dvalid.
    assign accept = (state == IDLE) && !busy;
    assign launch = accept && start;
    assign take   = (state == RUN) && valid;
    assign last   = ({1'b0, idx} == (len_q - LEN_ONE));

    assign prod = PW'(s0_w) * PW'(s0_a);
    assign ext  = ACC_W'(s1_p);

`ifdef MYPE_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MIN =
        {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_MAX = ~ACC_MIN;

    logic signed [ACC_W:0] sum;
    logic                  clamp;

    // One guard bit: the top two bits differ exactly on overflow.
    assign sum = s1_sub ? (ACC_W + 1)'(acc) - (ACC_W + 1)'(ext)
                        : (ACC_W + 1)'(acc) + (ACC_W + 1)'(ext);
    assign clamp = sum[ACC_W] ^ sum[ACC_W-1];

    always_comb begin
        acc_nx = sum[ACC_W-1:0];
        if (clamp) begin
            acc_nx = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ovf <= 1'b0;
        end else if (launch) begin
            ovf <= 1'b0;
        end else if (s1_v && clamp) begin
            ovf <= 1'b1;
        end
    end
`else
    assign acc_nx = s1_sub ? acc - ext : acc + ext;
    assign ovf    = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (launch) begin
                    state_nx = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (take && last) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= IDLE;
            busy      <= 1'b0;
            dvalid    <= 1'b0;
            dout      <= '0;
            idx       <= '0;
            len_q     <= '0;
            drain_cnt <= 1'b0;
            s0_v      <= 1'b0;
            s1_v      <= 1'b0;
            acc       <= '0;
        end else begin
            state     <= state_nx;
            busy      <= (state_nx != IDLE) || (state == DONE);
            dvalid    <= (state == DONE);
            drain_cnt <= (state == DRAIN) && !drain_cnt;
            s0_v      <= take;
            s1_v      <= s0_v;
            if (launch) begin
                len_q <= len;
                idx   <= '0;
                dout  <= '0;
                acc   <= '0;
            end else begin
                if (take) begin
                    idx <= idx + IDX_ONE;
                end
                if (s1_v) begin
                    acc <= acc_nx;
                end
                if (state == DONE) begin
                    dout <= acc;
                end
            end
        end
    end

    // RAM and datapath registers carry no reset; s0_v/s1_v qualify them.
    always_ff @(posedge aclk) begin
        if (accept && we) begin
            peram[addr] <= din;
        end
        if (take) begin
            s0_w   <= peram[idx];
            s0_a   <= ain;
            s0_sub <= subtract;
        end
        s1_p   <= prod;
        s1_sub <= s0_sub;
    end

endmodule

// File: tb/tb_mype_mac_v2.sv
// tb_mype_mac_v2: directed bench for mype_mac_v2 with a cycle-level
// expectation model and per-job literal result checks.
module tb_mype_mac_v2;

    localparam int DW  = 8;
    localparam int AW  = 16;
    localparam int LS  = 6;
    localparam int INF = 2147483647;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DW-1:0] din = '0;
    logic [LS-1:0] addr = '0;
    logic          we = 1'b0;
    logic          start = 1'b0;
    logic [LS:0]   len = '0;
    logic [DW-1:0] ain = '0;
    logic          valid = 1'b0;
    logic          subtract = 1'b0;
    logic          busy;
    logic          dvalid;
    logic [AW-1:0] dout;
    logic          ovf;

    mype_mac_v2 #(
        .DATA_W(DW),
        .ACC_W(AW),
        .L_RAM_SIZE(LS)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .din(din),
        .addr(addr),
        .we(we),
        .start(start),
        .len(len),
        .ain(ain),
        .valid(valid),
        .subtract(subtract),
        .busy(busy),
        .dvalid(dvalid),
        .dout(dout),
        .ovf(ovf)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Expectation model: job window [job_s, job_d] in edge counts.
    longint             shadow [64];
    longint             ain_q [$];
    bit                 sub_q [$];
    int                 jlen = 0;
    int                 job_s = INF;
    int                 job_d = INF;
    int                 last_e = 0;
    logic signed [63:0] job_res = 0;
    logic               job_ovf = 1'b0;
    logic signed [63:0] prev_dout = 0;
    logic               prev_ovf = 1'b0;
    bit                 mon_en = 1'b0;

    int                 dv_cnt = 0;
    int                 dv_cyc = 0;
    logic signed [63:0] dv_dout = 0;
    logic               dv_ovf = 1'b0;

    task automatic check(input string nm,
                         input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic signed [63:0] sx(input logic [AW-1:0] v);
        return {{(64-AW){v[AW-1]}}, v};
    endfunction

    function automatic bit mbusy(input int c);
        return (c >= job_s) && (c <= job_d);
    endfunction

    function automatic logic signed [63:0] edout(input int c);
        if (c < job_s) return prev_dout;
        if (c < job_d) return 0;
        return job_res;
    endfunction

    function automatic logic eovf(input int c);
        if (c < job_s) return prev_ovf;
        return job_ovf;
    endfunction

    // Dot product straight from the arithmetic rules.
    function automatic void model_job();
        longint acc = 0;
        bit     o = 1'b0;
        longint mx = (longint'(1) <<< (AW - 1)) - 1;
`ifdef MYPE_SAT_EN
        longint mn = -(longint'(1) <<< (AW - 1));
`endif
        foreach (ain_q[k]) begin
            longint p;
            p = shadow[k] * ain_q[k];
            acc = sub_q[k] ? acc - p : acc + p;
`ifdef MYPE_SAT_EN
            if (acc > mx) begin
                acc = mx;
                o = 1'b1;
            end else if (acc < mn) begin
                acc = mn;
                o = 1'b1;
            end
`else
            acc = acc & ((longint'(1) <<< AW) - 1);
            if (acc > mx) acc = acc - (longint'(1) <<< AW);
`endif
        end
        job_res = acc;
        job_ovf = o;
    endfunction

    always @(negedge aclk) begin
        if (mon_en) begin
            check("busy", busy, mbusy(cyc));
            check("dvalid", dvalid, (cyc == job_d));
            check("dout", sx(dout), edout(cyc));
            if (cyc < job_s || cyc >= job_d) begin
                check("ovf", ovf, eovf(cyc));
            end
            if (dvalid === 1'b1) begin
                dv_cnt++;
                dv_cyc  = cyc;
                dv_dout = sx(dout);
                dv_ovf  = ovf;
            end
        end
    end

    task automatic tick();
        @(negedge aclk);
        #1;
        we = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        subtract = 1'b0;
    endtask

    task automatic idle();
        tick();
    endtask

    task automatic do_write(input int a, input longint d);
        tick();
        we = 1'b1;
        addr = a[LS-1:0];
        din = d[DW-1:0];
        if (!mbusy(cyc)) shadow[a] = d;
    endtask

    task automatic do_start(input int n);
        tick();
        start = 1'b1;
        len = n[LS:0];
        if (!mbusy(cyc)) begin
            prev_dout = edout(cyc);
            prev_ovf  = eovf(cyc);
            job_s = cyc + 1;
            jlen  = n;
            ain_q.delete();
            sub_q.delete();
            if (n == 0) begin
                job_d   = cyc + 2;
                job_res = 0;
                job_ovf = 1'b0;
            end else begin
                job_d = INF;
            end
        end
    endtask

    task automatic do_elem(input longint a, input bit sb);
        tick();
        valid = 1'b1;
        ain = a[DW-1:0];
        subtract = sb;
        ain_q.push_back(a);
        sub_q.push_back(sb);
        if (ain_q.size() == jlen) begin
            last_e = cyc + 1;
            job_d  = cyc + 4;
            model_job();
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (cyc < job_d && n < 300) begin
            idle();
            n++;
        end
        if (n >= 300) begin
            failures++;
            $display("FAIL wait_done: got timeout expected dvalid");
        end
    endtask

    task automatic do_reset();
        tick();
        aresetn = 1'b0;
        job_s = INF;
        job_d = INF;
        prev_dout = 0;
        prev_ovf = 1'b0;
        tick();
        aresetn = 1'b1;
    endtask

    task automatic job_1234(input string nm);
        int n0;
        n0 = dv_cnt;
        do_start(4);
        do_elem(5, 1'b0);
        do_elem(6, 1'b0);
        do_elem(7, 1'b0);
        do_elem(8, 1'b0);
        wait_done();
        check({nm, "_model"}, job_res, 70);
        check({nm, "_dout"}, dv_dout, 70);
        check({nm, "_ovf"}, dv_ovf, 0);
        check({nm, "_lat"}, dv_cyc - last_e, 3);
        check({nm, "_cnt"}, dv_cnt, n0 + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        tick();
        mon_en = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_dvalid", dvalid, 0);
        check("rst_dout", sx(dout), 0);
        check("rst_ovf", ovf, 0);
        tick();
        aresetn = 1'b1;

        for (int i = 0; i < 4; i++) do_write(i, i + 1);
        job_1234("t1");

        do_start(4);
        do_elem(5, 1'b0);
        do_elem(6, 1'b1);
        do_elem(7, 1'b0);
        do_elem(8, 1'b1);
        wait_done();
        check("t2_model", job_res, -18);
        check("t2_dout", dv_dout, -18);

        do_write(0, -128);
        do_start(1);
        do_write(1, 99);
        idle();
        idle();
        do_elem(-128, 1'b0);
        wait_done();
        check("t3_model", job_res, 16384);
        check("t3_dout", dv_dout, 16384);
        do_start(2);
        do_elem(0, 1'b0);
        do_elem(1, 1'b0);
        wait_done();
        check("t3_readback", dv_dout, 2);

        for (int i = 0; i < 4; i++) do_write(i, 127);
        do_start(4);
        for (int i = 0; i < 4; i++) do_elem(127, 1'b0);
        wait_done();
`ifdef MYPE_SAT_EN
        check("t4_model", job_res, 32767);
        check("t4_dout", dv_dout, 32767);
        check("t4_ovf", dv_ovf, 1);
`else
        check("t4_model", job_res, -1020);
        check("t4_dout", dv_dout, -1020);
        check("t4_ovf", dv_ovf, 0);
`endif

        n0 = dv_cnt;
        do_start(0);
        do_start(0);
        do_start(0);
        wait_done();
        repeat (4) idle();
        check("t5_cnt", dv_cnt, n0 + 1);
        check("t5_dout", dv_dout, 0);
        check("t5_lat", dv_cyc - job_s, 1);

        for (int i = 0; i < 64; i++) do_write(i, i - 32);
        do_start(64);
        for (int i = 0; i < 64; i++) do_elem(1, 1'b0);
        wait_done();
        check("t6_model", job_res, -32);
        check("t6_dout", dv_dout, -32);
        do_start(1);
        do_elem(3, 1'b0);
        wait_done();
        check("t6_restart", dv_dout, -96);

        for (int i = 0; i < 4; i++) do_write(i, i + 1);
        n0 = dv_cnt;
        do_start(4);
        do_elem(5, 1'b0);
        do_elem(6, 1'b0);
        do_reset();
        repeat (6) idle();
        check("t7_cnt", dv_cnt, n0);
        check("t7_busy", busy, 0);
        check("t7_dout", sx(dout), 0);
        job_1234("t7");

        repeat (3) idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
